decoder_pipe: RTL and testbench
===============================

Name: decoder_pipe

Overview:
- Pipelined binary-to-one-hot decoder, the inverse of the team's priority-free one-hot encoders.
- Accepts an IN_W-bit code plus an enable over a valid/ready handshake and returns a registered 2**IN_W-bit one-hot word and a status bit over a second valid/ready handshake.
- Built hierarchically from two half-width decoders whose outputs are combined, mirroring the 4-level encoder tree.
- Keeps a saturating count of non-zero decodes for debug and status readout.

Parameters:
- IN_W, 4, code width; must be even, legal range 2..8.
- CNT_W, 16, width of the decode counter.
- OUT_W, 2**IN_W, output width; localparam derived from IN_W, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input code valid.
- in_ready  output  1  block can accept input this cycle.
- in_code  input  IN_W  binary code to decode.
- in_en  input  1  decode enable; 0 forces an all-zero output word.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts output.
- out_onehot  output  OUT_W  decoded one-hot word.
- out_status  output  1  1 when out_onehot is non-zero.
- cnt_clr  input  1  synchronous clear of decode_cnt.
- decode_cnt  output  CNT_W  saturating count of delivered non-zero words.

Behaviour:
- Reset, asynchronous on rst_n low: s1_valid, out_valid, out_onehot, out_status, decode_cnt and all stage registers go to 0. Any in-flight data is dropped, and no output handshake occurs on the cycle reset deasserts.
- Stage 1, on an input handshake (in_valid && in_ready):
  - Register hi_oh = decode of in_code[IN_W-1:IN_W/2] and lo_oh = decode of in_code[IN_W/2-1:0], each 2**(IN_W/2) bits.
  - Register en and set s1_valid.
- Stage 2, when stage 2 loads:
  - out_onehot[i*2**(IN_W/2)+j] = en & hi_oh[i] & lo_oh[j].
  - out_status = en.
  - Set out_valid.
- Latency: 2 cycles from input handshake to out_valid with out_ready held high. Throughput is 1 word per cycle.
- Backpressure:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s2_load. This is combinational from out_ready, which is acceptable.
  - On an output handshake with no s2_load, out_valid clears.
  - Stalled registers hold their values. out_onehot and out_status are stable while out_valid && !out_ready.
- Simultaneous output handshake and stage-2 load: new data replaces the old word, out_valid stays 1, no bubble.
- The output is always exactly one-hot or all zero. There are no invalid input codes.
- Counter:
  - Increments on an output handshake when out_status = 1.
  - Saturates at 2**CNT_W-1 and never wraps.
  - cnt_clr has priority over a same-cycle increment, so the result is 0.
- in_code and in_en are sampled only on an input handshake; they are don't-care otherwise.

Decomposition:
- Package decoder_pkg holds the default widths (DEC_IN_W = 4, DEC_CNT_W = 16) and the function half_w(IN_W).
- Sub-module decoder_half is a combinational N-to-2**N one-hot decoder with an enable. It is instantiated twice, for the high and low halves.
- The top level holds the pipeline registers, the handshake logic and the counter.

Test Plan:
- Reset then a single code: in_code = 4'hA, in_en = 1, out_ready = 1 -> out_valid 2 cycles later, out_onehot = 16'h0400, out_status = 1, decode_cnt = 1.
- Sweep: stream codes 0..15 back-to-back with out_ready = 1 -> 16 consecutive out_valid cycles, out_onehot = 1<<k in order, decode_cnt = 16.
- Disabled: in_code = 4'h5, in_en = 0 -> out_onehot = 16'h0000, out_status = 0, decode_cnt unchanged.
- Backpressure: send 3, 7, 12 with out_ready = 0 for 5 cycles ->
  - in_ready drops after 2 accepted words.
  - out_onehot holds 16'h0008.
  - On release, outputs are 16'h0008, 16'h0080, 16'h1000 with no loss or duplication.
- Counter edge: CNT_W = 2, deliver 5 non-zero words -> decode_cnt saturates at 3. Assert cnt_clr on the same cycle as an increment -> decode_cnt = 0.
- Reset mid-operation: assert rst_n low with both stages valid -> out_valid = 0 immediately. After release, no stale word appears and decode_cnt = 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared widths and helpers for the pipelined binary-to-one-hot decoder.
package decoder_pkg;

  localparam int DEC_IN_W  = 4;
  localparam int DEC_CNT_W = 16;

  function automatic int half_w(input int in_w);
    return in_w / 2;
  endfunction

endpackage

// File: rtl/decoder_half.sv
// Combinational N-to-2**N one-hot decoder with enable; all-zero when disabled.
module decoder_half #(
  parameter int N = 2
) (
  input  logic [N-1:0]      code_i,
  input  logic              en_i,
  output logic [2**N-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[code_i] = 1'b1;
  end

endmodule

// File: rtl/decoder_pipe.sv
// Two-stage pipelined decoder: half-width decodes are registered in stage 1,
// combined into the full one-hot word in stage 2, with a saturating delivery count.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter  int IN_W  = DEC_IN_W,
  parameter  int CNT_W = DEC_CNT_W,
  localparam int OUT_W = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic             out_status,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] decode_cnt
);

  localparam int HW = half_w(IN_W);
  localparam int HN = 2**HW;

  logic [HN-1:0]    hi_oh, lo_oh;
  logic [HN-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic             en_q, en_d;
  logic             s1_valid_q, s1_valid_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] onehot_q, onehot_d, comb_oh;
  logic             status_q, status_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_hs, out_hs, s2_load;

  decoder_half #(.N(HW)) u_hi (
    .code_i   (in_code[IN_W-1:HW]),
    .en_i     (in_en),
    .onehot_o (hi_oh)
  );

  decoder_half #(.N(HW)) u_lo (
    .code_i   (in_code[HW-1:0]),
    .en_i     (in_en),
    .onehot_o (lo_oh)
  );

  // Outer product of the two registered half decodes forms the full word.
  for (genvar i = 0; i < HN; i++) begin : g_hi
    for (genvar j = 0; j < HN; j++) begin : g_lo
      assign comb_oh[i*HN+j] = en_q & hi_q[i] & lo_q[j];
    end
  end

  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  always_comb begin
    hi_d        = in_hs ? hi_oh : hi_q;
    lo_d        = in_hs ? lo_oh : lo_q;
    en_d        = in_hs ? in_en : en_q;
    s1_valid_d  = in_hs || (s1_valid_q && !s2_load);
    out_valid_d = s2_load || (out_valid_q && !out_ready);
    onehot_d    = s2_load ? comb_oh : onehot_q;
    status_d    = s2_load ? en_q : status_q;
    cnt_d       = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (out_hs && status_q && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q        <= '0;
      lo_q        <= '0;
      en_q        <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      onehot_q    <= '0;
      status_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      en_q        <= en_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      onehot_q    <= onehot_d;
      status_q    <= status_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = onehot_q;
  assign out_status = status_q;
  assign decode_cnt = cnt_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// Randomized and directed bench for decoder_pipe against a queue-based transaction model.
module tb_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_code = '0;
  logic        in_en = 1'b0;
  logic        out_ready = 1'b0;
  logic        cnt_clr = 1'b0;

  logic        in_ready, out_valid, out_status;
  logic [15:0] out_onehot, decode_cnt;
  logic        in_ready_s, out_valid_s, out_status_s;
  logic [15:0] out_onehot_s;
  logic [1:0]  decode_cnt_s;

  always #5 clk = ~clk;

  decoder_pipe #(.IN_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_en(in_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_status(out_status), .cnt_clr(cnt_clr),
    .decode_cnt(decode_cnt)
  );

  decoder_pipe #(.IN_W(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_code(in_code), .in_en(in_en), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_onehot(out_onehot_s), .out_status(out_status_s), .cnt_clr(cnt_clr),
    .decode_cnt(decode_cnt_s)
  );

  typedef struct {
    logic [15:0] oh;
    logic        st;
    int unsigned acc;
  } item_t;

  item_t       q[$];
  int unsigned edge_n = 0;
  int unsigned m16 = 0;
  int unsigned m2 = 0;
  logic        exp_v = 1'b0;
  int          n_tot = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // A word is visible once it is the oldest in flight and at least one edge past acceptance.
  task automatic compare_outputs();
    exp_v = (q.size() > 0) && (edge_n > q[0].acc);
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("out_valid_s", 32'(out_valid_s), 32'(exp_v));
    if (exp_v) begin
      chk("out_onehot", 32'(out_onehot), 32'(q[0].oh));
      chk("out_status", 32'(out_status), 32'(q[0].st));
      chk("out_onehot_s", 32'(out_onehot_s), 32'(q[0].oh));
    end
    chk("decode_cnt", 32'(decode_cnt), m16);
    chk("decode_cnt_s", 32'(decode_cnt_s), m2);
  endtask

  task automatic step(input logic v, input logic [3:0] c, input logic e,
                      input logic r, input logic clr);
    logic  exp_rdy;
    item_t it;
    logic  inc;
    @(negedge clk);
    compare_outputs();
    in_valid = v; in_code = c; in_en = e; out_ready = r; cnt_clr = clr;
    #1;
    exp_rdy = (q.size() < 2) || r;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("in_ready_s", 32'(in_ready_s), 32'(exp_rdy));
    inc = 1'b0;
    if (exp_v && r) begin
      it  = q.pop_front();
      inc = it.st;
    end
    if (clr) begin
      m16 = 0; m2 = 0;
    end else if (inc) begin
      if (m16 < 65535) m16++;
      if (m2 < 3) m2++;
    end
    if (v && exp_rdy) begin
      it.oh  = e ? (16'h0001 << c) : 16'h0000;
      it.st  = e;
      it.acc = edge_n + 1;
      q.push_back(it);
    end
    edge_n++;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_decode_cnt", 32'(decode_cnt), 32'd0);
    chk("rst_out_onehot", 32'(out_onehot), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Single code, 2-cycle latency
    step(1'b1, 4'hA, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_out_onehot", 32'(out_onehot), 32'h0400);
    chk("lat_out_status", 32'(out_status), 32'd1);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("lat_decode_cnt", 32'(decode_cnt), 32'd1);
    idle(2);

    // Back-to-back sweep
    for (int k = 0; k < 16; k++) step(1'b1, 4'(k), 1'b1, 1'b1, 1'b0);
    idle(3);
    chk("sweep_decode_cnt", 32'(decode_cnt), 32'd17);

    // Disabled decode
    step(1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("dis_decode_cnt", 32'(decode_cnt), 32'd17);

    // Backpressure: 12 is held on the input until the pipe drains
    step(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 4'hC, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_onehot", 32'(out_onehot), 32'h0008);
    step(1'b1, 4'hC, 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("bp_decode_cnt", 32'(decode_cnt), 32'd20);

    // Saturation on the narrow counter, then clear colliding with an increment
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b1, 4'(k + 1), 1'b1, 1'b1, 1'b0);
    idle(3);
    chk("sat_decode_cnt_s", 32'(decode_cnt_s), 32'd3);
    chk("sat_decode_cnt", 32'(decode_cnt), 32'd5);
    step(1'b1, 4'h1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("clr_decode_cnt", 32'(decode_cnt), 32'd0);
    chk("clr_decode_cnt_s", 32'(decode_cnt_s), 32'd0);
    idle(2);

    // Randomized traffic
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 29) == 0));
    idle(3);

    // Reset with both stages occupied
    step(1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    compare_outputs();
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_decode_cnt", 32'(decode_cnt), 32'd0);
    q.delete();
    m16 = 0; m2 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    chk("post_rst_decode_cnt", 32'(decode_cnt), 32'd0);
    step(1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("post_rst_cnt_one", 32'(decode_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
